// File: rtl/channel_stream_src.sv
// channel_stream_src: streams len symbols from a small write-only buffer, optionally looping, with abort and done pulse
// Ports: clk/reset_b (async active-low); wr_en/wr_addr/wr_data buffer write (blocked while busy);
//   start/len/loop begin a stream; abort drops it; out_ready/out_data/out_valid/out_last stream handshake;
//   busy high while streaming; done pulses one cycle after the final non-looping transfer.
// Optional: CHANNEL_NOISE_EN adds noise_thresh and an LFSR that flips out_data[0] when lfsr[7:0] < noise_thresh.
module channel_stream_src #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
`ifdef CHANNEL_NOISE_EN
  input  logic [7:0]       noise_thresh,
`endif
  input  logic             clk,
  input  logic             reset_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      len,
  input  logic             loop,
  input  logic             abort,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_idx, w_idx_nx;
  logic [AW:0] r_len, w_len_nx;
  logic r_loop, w_loop_nx, w_valid_nx, w_done_nx, w_load, w_last_nx, w_xfer, w_start_ok;
  logic [WIDTH-1:0] w_data_nx;
  assign w_xfer     = out_valid & out_ready;
  assign w_start_ok = start && len != '0 && len <= DEPTH_L;
  assign w_last_nx  = {1'b0, w_idx_nx} == w_len_nx - 1'b1;
`ifdef CHANNEL_NOISE_EN
  logic [15:0] r_lfsr, w_lfsr_nx;
  // the flip decision is taken with the LFSR value that will be held while this symbol is presented
  assign w_lfsr_nx = (r_state == STREAM && !abort && w_xfer) ?
                     {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]} : r_lfsr;
  assign w_data_nx = r_mem[w_idx_nx] ^ WIDTH'(w_lfsr_nx[7:0] < noise_thresh);
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) r_lfsr <= 16'hACE1;
    else r_lfsr <= w_lfsr_nx;
`else
  assign w_data_nx = r_mem[w_idx_nx];
`endif
  always_ff @(posedge clk)
    if (wr_en && !busy && {1'b0, wr_addr} < DEPTH_L) r_mem[wr_addr] <= wr_data;
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_len_nx   = r_len;
    w_loop_nx  = r_loop;
    w_valid_nx = out_valid;
    w_done_nx  = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      IDLE: if (w_start_ok) begin
        w_state_nx = STREAM;
        w_idx_nx   = '0;
        w_len_nx   = len;
        w_loop_nx  = loop;
        w_valid_nx = 1'b1;
        w_load     = 1'b1;
      end
      STREAM: if (abort) begin
        w_state_nx = IDLE;
        w_valid_nx = 1'b0;
      end else if (w_xfer) begin
        if (!out_last) begin
          w_idx_nx = r_idx + 1'b1;
          w_load   = 1'b1;
        end else if (r_loop) begin
          w_idx_nx = '0;
          w_load   = 1'b1;
        end else begin
          w_state_nx = DONE;
          w_valid_nx = 1'b0;
          w_done_nx  = 1'b1;
        end
      end
      DONE: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_loop    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_len     <= w_len_nx;
      r_loop    <= w_loop_nx;
      out_valid <= w_valid_nx;
      out_last  <= w_load ? w_last_nx : out_last & w_valid_nx;
      busy      <= w_state_nx == STREAM;
      done      <= w_done_nx;
      if (w_load) out_data <= w_data_nx;
    end
endmodule

// File: tb/tb_channel_stream_src.sv
// tb_channel_stream_src: randomized self-checking bench for channel_stream_src against a symbol-sequence model
module tb_channel_stream_src;
  logic clk = 1'b0, reset_b = 1'b0, wr_en = 1'b0, start = 1'b0, loop = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic [4:0] len = '0;
  logic [1:0] out_data;
  logic out_valid, out_last, busy, done;
`ifdef CHANNEL_NOISE_EN
  logic [7:0] noise_thresh = '0;
`endif
  logic [1:0] model_mem [14];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  channel_stream_src dut (
`ifdef CHANNEL_NOISE_EN
    .noise_thresh(noise_thresh),
`endif
    .clk(clk), .reset_b(reset_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .loop(loop), .abort(abort), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done));
  task automatic write_mem(input logic [3:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 4'd14) model_mem[a] = d;
  endtask
  task automatic do_start(input int l, input bit lp);
    start = 1'b1; len = 5'(l); loop = lp;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({out_data, out_valid, out_last, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {out_data, out_valid, out_last, busy, done});
    end
    reset_b = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_full_stream();
    for (int i = 0; i < 14; i++) write_mem(4'(i), 2'(i % 4));
    out_ready = 1'b1;
    do_start(14, 1'b0);
    for (int k = 0; k < 14; k++) begin
      n_tests++;
      if ({out_valid, busy, out_data, out_last} !== {2'b11, model_mem[k], k == 13}) begin
        n_fail++; $display("FAIL full_sym%0d: got v=%b b=%b d=%0d l=%b expected v=1 b=1 d=%0d l=%b",
                           k, out_valid, busy, out_data, out_last, model_mem[k], k == 13);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({out_valid, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL full_done: got v=%b b=%b done=%b expected v=0 b=0 done=1", out_valid, busy, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_width: got done=%b expected 0", done); end
  endtask
  task automatic test_stall();
    int vc = 0, k = 0, cyc = 0;
    out_ready = 1'b0;
    do_start(4, 1'b0);
    while (out_valid && cyc < 30) begin
      n_tests++;
      if (out_data !== model_mem[k] || out_last !== (k == 3)) begin
        n_fail++; $display("FAIL stall_sym%0d: got d=%0d l=%b expected d=%0d l=%b", k, out_data, out_last, model_mem[k], k == 3);
      end
      vc++;
      out_ready = vc % 2 == 0;
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (vc != 8 || k != 4 || done !== 1'b1) begin
      n_fail++; $display("FAIL stall_count: got valid_cycles=%0d transfers=%0d done=%b expected 8 4 1", vc, k, done);
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_loop_abort();
    for (int i = 0; i < 14; i++) write_mem(4'(i), 2'($urandom));
    out_ready = 1'b1;
    do_start(3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({out_valid, out_data, out_last} !== {1'b1, model_mem[i % 3], i % 3 == 2}) begin
        n_fail++; $display("FAIL loop_sym%0d: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b",
                           i, out_valid, out_data, out_last, model_mem[i % 3], i % 3 == 2);
      end
      if (i == 7) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    n_tests++;
    if ({out_valid, out_last, busy, done} !== 4'b0) begin
      n_fail++; $display("FAIL loop_abort: got v=%b l=%b b=%b done=%b expected all 0", out_valid, out_last, busy, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL loop_abort_nodone: got done=%b expected 0", done); end
  endtask
  task automatic test_ignore();
    int bad [2] = '{0, 15};
    foreach (bad[j]) begin
      do_start(bad[j], 1'b0);
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL ignore_len%0d: got busy=%b v=%b expected 0 0", bad[j], busy, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    do_start(4, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = ~model_mem[2];
    start = 1'b1; len = 5'd2;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    n_tests++;
    if (out_data !== model_mem[0] || busy !== 1'b1) begin
      n_fail++; $display("FAIL ignore_restart: got d=%0d busy=%b expected d=%0d busy=1", out_data, busy, model_mem[0]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b1;
    do_start(4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (out_data !== model_mem[k] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL ignore_reread%0d: got d=%0d v=%b expected d=%0d v=1", k, out_data, out_valid, model_mem[k]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b1;
    do_start(14, 1'b0);
    repeat (5) @(negedge clk);
    reset_b = 1'b0;
    #1;
    n_tests++;
    if ({out_data, out_valid, out_last, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 000000", {out_data, out_valid, out_last, busy, done});
    end
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({out_valid, busy, done} !== 3'b0) begin
      n_fail++; $display("FAIL midreset_idle: got v=%b b=%b done=%b expected 0 0 0", out_valid, busy, done);
    end
    do_start(14, 1'b0);
    for (int k = 0; k < 14; k++) begin
      n_tests++;
      if (out_data !== model_mem[k] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL midreset_sym%0d: got d=%0d v=%b expected d=%0d v=1", k, out_data, out_valid, model_mem[k]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int l, ab, k = 0, cyc = 0;
      bit lp, fin = 1'b0, exp_done = 1'b0;
      for (int w = 0; w < 4; w++) write_mem(4'($urandom_range(0, 15)), 2'($urandom));
      l  = (it < 3) ? 1 : $urandom_range(1, 14);
      lp = 1'($urandom);
      ab = lp ? $urandom_range(0, 3 * l) : ($urandom_range(0, 2) == 0 ? $urandom_range(0, l - 1) : -1);
      do_start(l, lp);
      while (!fin && cyc < 400) begin
        n_tests++;
        if ({out_valid, busy, out_data, out_last} !== {2'b11, model_mem[k % l], k % l == l - 1}) begin
          n_fail++; $display("FAIL rand_it%0d_k%0d: got v=%b b=%b d=%0d l=%b expected v=1 b=1 d=%0d l=%b",
                             it, k, out_valid, busy, out_data, out_last, model_mem[k % l], k % l == l - 1);
        end
        if (k == ab) begin
          abort = 1'b1; out_ready = 1'($urandom); fin = 1'b1;
        end else begin
          out_ready = $urandom_range(0, 3) != 0;
          if (out_ready) begin
            if (!lp && k == l - 1) begin fin = 1'b1; exp_done = 1'b1; end
            k++;
          end
        end
        @(negedge clk);
        abort = 1'b0;
        cyc++;
      end
      n_tests++;
      if (!fin || {out_valid, busy, done} !== {2'b00, exp_done}) begin
        n_fail++; $display("FAIL rand_end_it%0d: got fin=%b v=%b b=%b done=%b expected fin=1 v=0 b=0 done=%b",
                           it, fin, out_valid, busy, done, exp_done);
      end
      out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rand_idle_it%0d: got done=%b busy=%b expected 0 0", it, done, busy);
      end
    end
  endtask
`ifdef CHANNEL_NOISE_EN
  task automatic test_noise();
    logic [15:0] s = 16'hACE1;
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    noise_thresh = 8'hFF;
    out_ready = 1'b1;
    do_start(14, 1'b0);
    for (int k = 0; k < 14; k++) begin
      n_tests++;
      if (out_data !== (model_mem[k] ^ 2'(s[7:0] != 8'hFF))) begin
        n_fail++; $display("FAIL noise_sym%0d: got d=%0d expected d=%0d", k, out_data, model_mem[k] ^ 2'(s[7:0] != 8'hFF));
      end
      s = {s[14:0], ^(s & 16'hB400)};
      @(negedge clk);
    end
    noise_thresh = 8'h00;
    @(negedge clk);
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_full_stream();
    test_stall();
    test_loop_abort();
    test_ignore();
    test_reset_mid();
    test_random();
`ifdef CHANNEL_NOISE_EN
    test_noise();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/channel_stream_src.md
CHANNEL_STREAM_SRC -- requirements
Module: channel_stream_src

Interface
REQ-001 SHALL have parameter WIDTH, default 2: symbol width in bits.
REQ-002 SHALL have parameter DEPTH, default 14: symbol buffer depth.
REQ-003 SHALL have parameter AW, default 4: address width, with 2^AW >= DEPTH.
REQ-004 SHALL have port clk  in  1  single system clock, rising edge.
REQ-005 SHALL have port reset_b  in  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  in  1  buffer write strobe.
REQ-007 SHALL have port wr_addr  in  AW  buffer write address.
REQ-008 SHALL have port wr_data  in  WIDTH  buffer write data.
REQ-009 SHALL have port start  in  1  begin streaming.
REQ-010 SHALL have port len  in  AW+1  number of symbols to stream, valid range 1..DEPTH.
REQ-011 SHALL have port loop  in  1  repeat mode, sampled with start.
REQ-012 SHALL have port abort  in  1  terminate the stream.
REQ-013 SHALL have port out_ready  in  1  sink ready.
REQ-014 SHALL have port out_data  out  WIDTH  current symbol.
REQ-015 SHALL have port out_valid  out  1  symbol valid.
REQ-016 SHALL have port out_last  out  1  current symbol is index len-1.
REQ-017 SHALL have port busy  out  1  high in STREAM.
REQ-018 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-019 SHALL be a three-state FSM: IDLE, STREAM, DONE; all outputs SHALL be registered.
REQ-020 SHALL write mem[wr_addr] <= wr_data on wr_en only when not busy, and SHALL ignore writes with wr_addr >= DEPTH.
REQ-021 SHALL, in IDLE, on start with len in 1..DEPTH, latch len and loop, set index 0, and enter STREAM with out_valid=1 and out_data=mem[0] from the next cycle.
REQ-022 SHALL ignore start when len=0, len>DEPTH, or the FSM is not in IDLE.
REQ-023 SHALL treat a transfer as out_valid&&out_ready on a rising edge, allowing at most one transfer per cycle and sustaining full throughput while out_ready stays high.
REQ-024 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on a transfer of a symbol with index < len-1, advance index by 1 and present mem[index+1] next cycle.
REQ-026 SHALL, on a transfer with out_last=1 and loop latched, wrap index to 0 with out_valid remaining 1, and emit no bubble.
REQ-027 SHALL, on a transfer with out_last=1 and loop clear, clear out_valid and enter DONE.
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL, on abort in STREAM, enter IDLE next cycle with out_valid=0 and no done pulse; abort has priority over a simultaneous transfer, and abort in IDLE/DONE has no effect.
REQ-030 SHALL, with len=1, assert out_last on the only symbol.

Reset
REQ-031 SHALL, on reset_b low, asynchronously force: state IDLE, index 0, out_valid 0, out_last 0, busy 0, done 0, out_data 0, latched len/loop 0.
REQ-032 SHALL NOT reset buffer contents.
REQ-033 SHALL, when reset occurs mid-stream, drop the stream with no done pulse, and SHALL operate normally from the first rising edge after reset_b rises.

Configuration
REQ-034 SHALL, with CHANNEL_NOISE_EN defined, add input noise_thresh (8 bits) and a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded 16'hACE1 on reset.
REQ-035 SHALL, with CHANNEL_NOISE_EN defined, advance the LFSR once per transfer.
REQ-036 SHALL, with CHANNEL_NOISE_EN defined, invert bit 0 of out_data when lfsr[7:0] < noise_thresh; the decision uses the LFSR state held while the symbol is presented.
REQ-037 SHALL, without CHANNEL_NOISE_EN, have no noise_thresh port and no LFSR, and SHALL output out_data equal to the buffer contents exactly.

Verification
REQ-038 SHALL cover: write mem[0..13]=0,1,2,3,0,1,...; start with len=14, loop=0, out_ready=1 -> 14 consecutive transfers in order, out_last on the 14th, done pulse 1 cycle after it, then IDLE.
REQ-039 SHALL cover: len=4, out_ready toggling 1/0 every cycle -> 4 transfers, data held stable during stalls, total 8 cycles of out_valid.
REQ-040 SHALL cover: len=3, loop=1 -> sequence mem0,1,2,0,1,2,... with no bubbles; abort after 7 transfers -> out_valid=0 next cycle, no done pulse.
REQ-041 SHALL cover: start with len=0 and with len=15 -> busy stays 0; wr_en during STREAM -> buffer unchanged when re-read.
REQ-042 SHALL cover: reset_b pulsed low mid-stream -> all outputs 0 immediately, buffer contents preserved on the next stream.
REQ-043 SHALL cover, with CHANNEL_NOISE_EN: noise_thresh=0 -> no flips; noise_thresh=255 -> bit 0 flipped whenever lfsr[7:0]!=8'hFF, matching a reference LFSR model.
